// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the AXI4-Lite command-to-bus master.
package axi_lite_pkg;

  // AXI4-Lite BRESP/RRESP encodings
  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  // Transaction sequencer states
  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    RESP
  } state_t;

  localparam int ERR_CNT_W = 16;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] cnt);
    return (cnt == {ERR_CNT_W{1'b1}}) ? cnt : cnt + ERR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/axi_lite_master_if.sv
// Command/response handshake plus the AXI4-Lite bus, bundled for the master.
interface axi_lite_master_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  // Command side
  logic                CMD_VALID;
  logic                CMD_READY;
  logic                CMD_WRITE;
  logic [ADDR_W-1:0]   CMD_ADDR;
  logic [DATA_W-1:0]   CMD_WDATA;
  logic [DATA_W/8-1:0] CMD_WSTRB;
  // Response side
  logic                RSP_VALID;
  logic                RSP_READY;
  logic                RSP_WRITE;
  logic [DATA_W-1:0]   RSP_RDATA;
  logic [1:0]          RSP_RESP;
  // AXI4-Lite write address / data / response
  logic [ADDR_W-1:0]   AXI_CTRL_AWADDR;
  logic [2:0]          AXI_CTRL_AWPROT;
  logic                AXI_CTRL_AWVALID;
  logic                AXI_CTRL_AWREADY;
  logic [DATA_W-1:0]   AXI_CTRL_WDATA;
  logic [DATA_W/8-1:0] AXI_CTRL_WSTRB;
  logic                AXI_CTRL_WVALID;
  logic                AXI_CTRL_WREADY;
  logic [1:0]          AXI_CTRL_BRESP;
  logic                AXI_CTRL_BVALID;
  logic                AXI_CTRL_BREADY;
  // AXI4-Lite read address / data
  logic [ADDR_W-1:0]   AXI_CTRL_ARADDR;
  logic [2:0]          AXI_CTRL_ARPROT;
  logic                AXI_CTRL_ARVALID;
  logic                AXI_CTRL_ARREADY;
  logic [DATA_W-1:0]   AXI_CTRL_RDATA;
  logic [1:0]          AXI_CTRL_RRESP;
  logic                AXI_CTRL_RVALID;
  logic                AXI_CTRL_RREADY;

  modport master (
    input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, CMD_WSTRB, RSP_READY,
    input  AXI_CTRL_AWREADY, AXI_CTRL_WREADY, AXI_CTRL_BRESP, AXI_CTRL_BVALID,
    input  AXI_CTRL_ARREADY, AXI_CTRL_RDATA, AXI_CTRL_RRESP, AXI_CTRL_RVALID,
    output CMD_READY, RSP_VALID, RSP_WRITE, RSP_RDATA, RSP_RESP,
    output AXI_CTRL_AWADDR, AXI_CTRL_AWPROT, AXI_CTRL_AWVALID,
    output AXI_CTRL_WDATA, AXI_CTRL_WSTRB, AXI_CTRL_WVALID, AXI_CTRL_BREADY,
    output AXI_CTRL_ARADDR, AXI_CTRL_ARPROT, AXI_CTRL_ARVALID, AXI_CTRL_RREADY
  );

  modport slave (
    output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, CMD_WSTRB, RSP_READY,
    output AXI_CTRL_AWREADY, AXI_CTRL_WREADY, AXI_CTRL_BRESP, AXI_CTRL_BVALID,
    output AXI_CTRL_ARREADY, AXI_CTRL_RDATA, AXI_CTRL_RRESP, AXI_CTRL_RVALID,
    input  CMD_READY, RSP_VALID, RSP_WRITE, RSP_RDATA, RSP_RESP,
    input  AXI_CTRL_AWADDR, AXI_CTRL_AWPROT, AXI_CTRL_AWVALID,
    input  AXI_CTRL_WDATA, AXI_CTRL_WSTRB, AXI_CTRL_WVALID, AXI_CTRL_BREADY,
    input  AXI_CTRL_ARADDR, AXI_CTRL_ARPROT, AXI_CTRL_ARVALID, AXI_CTRL_RREADY
  );
endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one AXI write or
// read transaction out, one response back, with a saturating error counter.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic                 AXI_CTRL_ACLK,
  input  logic                 AXI_CTRL_ARESET,
  axi_lite_master_if.master    bus,
  output logic [ERR_CNT_W-1:0] ERR_CNT
);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wstrb;
  logic                r_write;
  logic                r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
  logic                r_aw_done, r_w_done, r_b_done, r_ar_done, r_r_done;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  resp_t               r_rsp_resp;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  // Channel handshakes in the current cycle
  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  assign w_aw_hs = r_awvalid & bus.AXI_CTRL_AWREADY;
  assign w_w_hs  = r_wvalid  & bus.AXI_CTRL_WREADY;
  assign w_b_hs  = r_bready  & bus.AXI_CTRL_BVALID;
  assign w_ar_hs = r_arvalid & bus.AXI_CTRL_ARREADY;
  assign w_r_hs  = r_rready  & bus.AXI_CTRL_RVALID;

  // A channel counts as finished if it completed earlier or completes now,
  // so the state can leave in the same cycle as the last handshake.
  logic w_wr_exit, w_rd_exit, w_enter_resp;
  assign w_wr_exit = (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs) & (r_b_done | w_b_hs);
  assign w_rd_exit = (r_ar_done | w_ar_hs) & (r_r_done | w_r_hs);
  assign w_enter_resp = ((r_state == WRITE) & w_wr_exit) | ((r_state == READ) & w_rd_exit);

  // Response code that RSP_RESP will hold once RESP is entered
  resp_t w_new_resp;
  assign w_new_resp = (r_state == WRITE) ? (w_b_hs ? resp_t'(bus.AXI_CTRL_BRESP) : r_rsp_resp)
                                         : (w_r_hs ? resp_t'(bus.AXI_CTRL_RRESP) : r_rsp_resp);

  // Transaction sequencer with all bus controls held in registers
  always_ff @(posedge AXI_CTRL_ACLK or posedge AXI_CTRL_ARESET) begin
    // NOTE: state is updated with non-blocking assignments so every branch
    // reads the pre-edge values, matching what the hardware flops see.
    if (AXI_CTRL_ARESET) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_write     <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_b_done    <= 1'b0;
      r_ar_done   <= 1'b0;
      r_r_done    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= OKAY;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.CMD_VALID) begin
            r_addr    <= bus.CMD_ADDR;
            r_wdata   <= bus.CMD_WDATA;
            r_wstrb   <= bus.CMD_WSTRB;
            r_write   <= bus.CMD_WRITE;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_b_done  <= 1'b0;
            r_ar_done <= 1'b0;
            r_r_done  <= 1'b0;
            if (bus.CMD_WRITE) begin
              r_state   <= WRITE;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_bready  <= 1'b1;
            end else begin
              r_state   <= READ;
              r_arvalid <= 1'b1;
              r_rready  <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          // B may legally arrive before AW/W finish; capture it whenever seen
          if (w_b_hs) begin
            r_b_done   <= 1'b1;
            r_rsp_resp <= resp_t'(bus.AXI_CTRL_BRESP);
          end
          if (w_wr_exit) begin
            r_state     <= RESP;
            r_bready    <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_valid <= 1'b1;
          end
        end
        READ: begin
          if (w_ar_hs) begin
            r_arvalid <= 1'b0;
            r_ar_done <= 1'b1;
          end
          if (w_r_hs) begin
            r_r_done    <= 1'b1;
            r_rsp_rdata <= bus.AXI_CTRL_RDATA;
            r_rsp_resp  <= resp_t'(bus.AXI_CTRL_RRESP);
          end
          if (w_rd_exit) begin
            r_state     <= RESP;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (bus.RSP_READY) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Count non-OKAY responses on RESP entry, sticking at full scale
  always_ff @(posedge AXI_CTRL_ACLK or posedge AXI_CTRL_ARESET) begin
    if (AXI_CTRL_ARESET) begin
      r_err_cnt <= '0;
    end else if (w_enter_resp && (w_new_resp != OKAY)) begin
      r_err_cnt <= sat_inc(r_err_cnt);
    end
  end

  // CMD_READY is decoded from the state register alone, so no path exists
  // from CMD_VALID back to CMD_READY.
  assign bus.CMD_READY        = (r_state == IDLE);
  assign bus.RSP_VALID        = r_rsp_valid;
  assign bus.RSP_WRITE        = r_write;
  assign bus.RSP_RDATA        = r_rsp_rdata;
  assign bus.RSP_RESP         = r_rsp_resp;
  assign bus.AXI_CTRL_AWADDR  = r_addr;
  assign bus.AXI_CTRL_AWPROT  = 3'b000;
  assign bus.AXI_CTRL_AWVALID = r_awvalid;
  assign bus.AXI_CTRL_WDATA   = r_wdata;
  assign bus.AXI_CTRL_WSTRB   = r_wstrb;
  assign bus.AXI_CTRL_WVALID  = r_wvalid;
  assign bus.AXI_CTRL_BREADY  = r_bready;
  assign bus.AXI_CTRL_ARADDR  = r_addr;
  assign bus.AXI_CTRL_ARPROT  = 3'b000;
  assign bus.AXI_CTRL_ARVALID = r_arvalid;
  assign bus.AXI_CTRL_RREADY  = r_rready;
  assign ERR_CNT              = r_err_cnt;

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master: a small register-file slave with
// programmable per-channel timing, a scoreboard queue filled at command issue,
// and a monitor that checks each response the first cycle it is presented.
module tb_axi_lite_master;
  import axi_lite_pkg::*;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] err_cnt;

  axi_lite_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  axi_lite_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .AXI_CTRL_ACLK   (clk),
    .AXI_CTRL_ARESET (rst),
    .bus             (bus.master),
    .ERR_CNT         (err_cnt)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard entry: expected response fields plus the cycle it must appear in
  typedef struct {
    logic        wr;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic [15:0] err;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];

  function automatic exp_t mk_exp(input logic wr, input logic [31:0] rdata,
                                  input logic [1:0] resp, input logic [15:0] err, input int cyc);
    exp_t e;
    e.wr = wr; e.rdata = rdata; e.resp = resp; e.err = err; e.cyc = cyc;
    return e;
  endfunction

  // Cycle number relative to the last command accept (accept cycle = 0)
  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else if (bus.CMD_VALID && bus.CMD_READY) cyc <= 1;
    else cyc <= cyc + 1;
  end

  // Slave model: 4-word register file, word 0 reads as STENCIL_DONE=1
  int         aw_at = 2, w_at = 2, b_at = 2, ar_at = 2, r_at = 2;
  logic [1:0] s_bresp = 2'b00, s_rresp = 2'b00;
  logic [31:0] mem [4];
  logic       s_b_done, s_r_done, s_is_wr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_b_done <= 1'b1;
      s_r_done <= 1'b1;
      s_is_wr  <= 1'b0;
      mem      <= '{32'h0000_0001, 32'h0, 32'h0, 32'h0};
    end else begin
      if (bus.CMD_VALID && bus.CMD_READY) begin
        s_is_wr  <= bus.CMD_WRITE;
        s_b_done <= 1'b0;
        s_r_done <= 1'b0;
      end
      if (bus.AXI_CTRL_BVALID && bus.AXI_CTRL_BREADY) s_b_done <= 1'b1;
      if (bus.AXI_CTRL_RVALID && bus.AXI_CTRL_RREADY) s_r_done <= 1'b1;
      if (bus.AXI_CTRL_WVALID && bus.AXI_CTRL_WREADY) begin
        for (int i = 0; i < 4; i++)
          if (bus.AXI_CTRL_WSTRB[i])
            mem[bus.AXI_CTRL_AWADDR[3:2]][8*i +: 8] <= bus.AXI_CTRL_WDATA[8*i +: 8];
      end
    end
  end

  always @(negedge clk) begin
    bus.AXI_CTRL_AWREADY = (cyc >= aw_at);
    bus.AXI_CTRL_WREADY  = (cyc >= w_at);
    bus.AXI_CTRL_BVALID  = s_is_wr && !s_b_done && (cyc >= b_at);
    bus.AXI_CTRL_BRESP   = s_bresp;
    bus.AXI_CTRL_ARREADY = (cyc >= ar_at);
    bus.AXI_CTRL_RVALID  = !s_is_wr && !s_r_done && (cyc >= r_at);
    bus.AXI_CTRL_RDATA   = bus.AXI_CTRL_RVALID ? mem[bus.AXI_CTRL_ARADDR[3:2]] : 32'h0;
    bus.AXI_CTRL_RRESP   = s_rresp;
  end

  // Monitor: compare each response on the first cycle RSP_VALID is seen
  logic mon_seen = 1'b0;
  exp_t mon_e;
  always @(posedge clk) begin
    #1;
    if (rst || !bus.RSP_VALID) begin
      mon_seen = 1'b0;
    end else if (!mon_seen) begin
      mon_seen = 1'b1;
      check("sb_pending", 64'(sb_q.size() > 0), 64'd1);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        check("rsp_write", bus.RSP_WRITE, mon_e.wr);
        check("rsp_rdata", bus.RSP_RDATA, mon_e.rdata);
        check("rsp_resp",  bus.RSP_RESP,  mon_e.resp);
        check("err_cnt",   err_cnt,       mon_e.err);
        check("rsp_cycle", cyc,           mon_e.cyc);
      end
    end
  end

  // Stimulus helpers
  task automatic set_cmd(input logic wr, input logic [3:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input exp_t e);
    bus.CMD_VALID = 1'b1;
    bus.CMD_WRITE = wr;
    bus.CMD_ADDR  = addr;
    bus.CMD_WDATA = data;
    bus.CMD_WSTRB = strb;
    sb_q.push_back(e);
  endtask

  // Returns one time unit into cycle 1 after the accept edge
  task automatic wait_accept();
    int n = 0;
    while (!bus.CMD_READY && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accept", bus.CMD_READY, 1'b1);
    @(posedge clk);
    #1;
    bus.CMD_VALID = 1'b0;
  endtask

  task automatic issue(input logic wr, input logic [3:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input exp_t e);
    @(negedge clk);
    set_cmd(wr, addr, data, strb, e);
    wait_accept();
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb_q.size() != 0 || bus.RSP_VALID) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rsp_outstanding", sb_q.size(), 0);
  endtask

  task automatic run_wr(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                        input int aw, input int w, input int b, input logic [1:0] resp,
                        input logic [15:0] exp_err, input int exp_cyc);
    aw_at = aw; w_at = w; b_at = b; s_bresp = resp;
    issue(1'b1, addr, data, strb, mk_exp(1'b1, 32'h0, resp, exp_err, exp_cyc));
    wait_idle();
  endtask

  task automatic run_rd(input logic [3:0] addr, input int ar, input int r, input logic [1:0] resp,
                        input logic [31:0] exp_rdata, input logic [15:0] exp_err, input int exp_cyc);
    ar_at = ar; r_at = r; s_rresp = resp;
    issue(1'b0, addr, 32'h0, 4'h0, mk_exp(1'b0, exp_rdata, resp, exp_err, exp_cyc));
    wait_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.CMD_VALID = 1'b0;
    bus.CMD_WRITE = 1'b0;
    bus.CMD_ADDR  = '0;
    bus.CMD_WDATA = '0;
    bus.CMD_WSTRB = '0;
    bus.RSP_READY = 1'b1;
    rst = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", bus.CMD_READY, 1'b1);
    check("rst_awvalid",   bus.AXI_CTRL_AWVALID, 1'b0);
    check("rst_wvalid",    bus.AXI_CTRL_WVALID, 1'b0);
    check("rst_bready",    bus.AXI_CTRL_BREADY, 1'b0);
    check("rst_arvalid",   bus.AXI_CTRL_ARVALID, 1'b0);
    check("rst_rready",    bus.AXI_CTRL_RREADY, 1'b0);
    check("rst_rsp_valid", bus.RSP_VALID, 1'b0);
    check("rst_rsp_rdata", bus.RSP_RDATA, 32'h0);
    check("rst_rsp_resp",  bus.RSP_RESP, 2'b00);
    check("rst_awaddr",    bus.AXI_CTRL_AWADDR, 4'h0);
    check("rst_err_cnt",   err_cnt, 16'h0);
    rst = 1'b0;

    // STENCIL_SRC write at minimum latency, then status reads
    run_wr(4'h8, 32'h1000_0000, 4'hF, 2, 2, 2, OKAY, 16'd0, 3);
    check("stencil_src", mem[2], 32'h1000_0000);
    run_rd(4'h0, 2, 2, OKAY, 32'h0000_0001, 16'd0, 3);
    run_rd(4'h4, 2, 3, OKAY, 32'h0000_0000, 16'd0, 4);
    run_rd(4'h8, 1, 1, OKAY, 32'h1000_0000, 16'd0, 2);

    // Byte strobes: lanes 0 and 2 only
    run_wr(4'h4, 32'hAABB_CCDD, 4'b0101, 1, 1, 1, OKAY, 16'd0, 2);
    run_rd(4'h4, 1, 2, OKAY, 32'h00BB_00DD, 16'd0, 3);

    // Skewed slave: AWREADY@2, WREADY@5, BVALID@6 -> RSP_VALID@7
    aw_at = 2; w_at = 5; b_at = 6; s_bresp = OKAY;
    issue(1'b1, 4'hC, 32'h1234_5678, 4'hF, mk_exp(1'b1, 32'h0, OKAY, 16'd0, 7));
    for (int c = 1; c <= 7; c++) begin
      check($sformatf("skew_awvalid_c%0d", c), bus.AXI_CTRL_AWVALID, c <= 2);
      check($sformatf("skew_wvalid_c%0d", c),  bus.AXI_CTRL_WVALID,  c <= 5);
      check($sformatf("skew_rsp_valid_c%0d", c), bus.RSP_VALID, c == 7);
      @(posedge clk);
      #1;
    end
    wait_idle();

    // B handshake ahead of W and AW
    run_wr(4'hC, 32'hCAFE_F00D, 4'hF, 3, 2, 1, OKAY, 16'd0, 4);
    run_rd(4'hC, 2, 2, OKAY, 32'hCAFE_F00D, 16'd0, 3);

    // Error responses, including EXOKAY which is also not OKAY
    run_wr(4'hC, 32'h0000_0005, 4'hF, 2, 2, 2, SLVERR, 16'd1, 3);
    run_rd(4'h4, 2, 2, DECERR, 32'h00BB_00DD, 16'd2, 3);
    run_rd(4'h0, 2, 2, OKAY, 32'h0000_0001, 16'd2, 3);
    run_rd(4'h0, 2, 2, EXOKAY, 32'h0000_0001, 16'd3, 3);

    // Saturation from a preloaded count
    @(negedge clk);
    force dut.r_err_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.r_err_cnt;
    check("err_preload", err_cnt, 16'hFFFE);
    run_wr(4'hC, 32'h0000_0001, 4'hF, 2, 2, 2, SLVERR, 16'hFFFF, 3);
    run_rd(4'h0, 2, 2, DECERR, 32'h0000_0001, 16'hFFFF, 3);
    run_rd(4'h0, 2, 2, OKAY, 32'h0000_0001, 16'hFFFF, 3);

    // Response backpressure with a second command already pending
    bus.RSP_READY = 1'b0;
    aw_at = 2; w_at = 2; b_at = 2; s_bresp = OKAY;
    issue(1'b0, 4'h0, 32'h0, 4'h0, mk_exp(1'b0, 32'h0000_0001, OKAY, 16'hFFFF, 3));
    begin
      int n = 0;
      while (!bus.RSP_VALID && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    set_cmd(1'b1, 4'h8, 32'h2000_0000, 4'hF, mk_exp(1'b1, 32'h0, OKAY, 16'hFFFF, 3));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_rsp_valid", bus.RSP_VALID, 1'b1);
      check("bp_rsp_rdata", bus.RSP_RDATA, 32'h0000_0001);
      check("bp_rsp_write", bus.RSP_WRITE, 1'b0);
      check("bp_cmd_ready", bus.CMD_READY, 1'b0);
    end
    bus.RSP_READY = 1'b1;
    @(posedge clk);
    #1;
    check("bp_after_hs_cmd_ready", bus.CMD_READY, 1'b1);
    check("bp_after_hs_rsp_valid", bus.RSP_VALID, 1'b0);
    check("bp_no_early_accept", bus.AXI_CTRL_AWVALID, 1'b0);
    wait_accept();
    check("bp_accepted_awvalid", bus.AXI_CTRL_AWVALID, 1'b1);
    wait_idle();
    check("bp_write_landed", mem[2], 32'h2000_0000);

    // Asynchronous reset in the middle of a write
    aw_at = 100; w_at = 100; b_at = 100;
    issue(1'b1, 4'h8, 32'hDEAD_BEEF, 4'hF, mk_exp(1'b1, 32'h0, OKAY, 16'hFFFF, 0));
    @(negedge clk);
    check("mid_awvalid", bus.AXI_CTRL_AWVALID, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("arst_awvalid",   bus.AXI_CTRL_AWVALID, 1'b0);
    check("arst_wvalid",    bus.AXI_CTRL_WVALID, 1'b0);
    check("arst_bready",    bus.AXI_CTRL_BREADY, 1'b0);
    check("arst_rsp_valid", bus.RSP_VALID, 1'b0);
    check("arst_err_cnt",   err_cnt, 16'h0);
    if (sb_q.size() > 0) void'(sb_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    aw_at = 2; w_at = 2; b_at = 2;
    check("post_rst_cmd_ready", bus.CMD_READY, 1'b1);
    run_rd(4'h0, 2, 2, OKAY, 32'h0000_0001, 16'd0, 3);
    run_rd(4'h8, 2, 2, OKAY, 32'h0000_0000, 16'd0, 3);

    wait_idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
- Single-outstanding AXI4-Lite initiator that turns a simple command/response handshake into one AXI-Lite write or read transaction.
- Drives the AXI_CTRL_* slave port of the stencil register controller, e.g. from an on-chip sequencer or a bench-side bus functional model.
- Also usable as a generic control-plane master elsewhere in the design.
- Holds the AXI address, data and response in registers; counts error responses.

Parameters:
- ADDR_W, 4, AXI address width (byte address).
- DATA_W, 32, AXI data width; the strobe width is DATA_W/8.

Ports:
- AXI_CTRL_ACLK  in  1  clock.
- AXI_CTRL_ARESET  in  1  asynchronous, active-high reset.
- CMD_VALID  in  1  command offered.
- CMD_READY  out  1  command accepted when high together with CMD_VALID.
- CMD_WRITE  in  1  1 = write, 0 = read.
- CMD_ADDR  in  ADDR_W  byte address.
- CMD_WDATA  in  DATA_W  write data.
- CMD_WSTRB  in  DATA_W/8  write strobes.
- RSP_VALID  out  1  response available.
- RSP_READY  in  1  response consumed.
- RSP_WRITE  out  1  copy of CMD_WRITE for this response.
- RSP_RDATA  out  DATA_W  read data; 0 for writes.
- RSP_RESP  out  2  BRESP or RRESP.
- ERR_CNT  out  16  saturating count of responses other than OKAY.
- AXI_CTRL_AWADDR/AWPROT/AWVALID out, AWREADY in; AXI_CTRL_WDATA/WSTRB/WVALID out, WREADY in; AXI_CTRL_BRESP/BVALID in, BREADY out.
- AXI_CTRL_ARADDR/ARPROT/ARVALID out, ARREADY in; AXI_CTRL_RDATA/RRESP/RVALID in, RREADY out.
- All AXI ports have standard AXI4-Lite widths, with ADDR_W and DATA_W applied.

Behaviour:
- Reset: the whole block resets asynchronously on AXI_CTRL_ARESET high. All VALID and READY outputs to AXI are 0. RSP_VALID=0. ERR_CNT=0. Address, data, RSP_RDATA and RSP_RESP registers are 0. State is IDLE.
  - Reset mid-transaction abandons the transaction with no response. The partner slave is reset by the same system reset.
- AWPROT and ARPROT are constant 3'b000.
- FSM states: IDLE, WRITE, READ, RESP.
- CMD_READY = (state==IDLE), combinational from the state register only. There is no combinational path from CMD_VALID.
- IDLE, on command accept:
  - Latch addr, wdata, wstrb and write.
  - Write: next state WRITE. AWVALID=WVALID=BREADY=1 from the next cycle, which is cycle 1 after accept.
  - Read: next state READ. ARVALID=RREADY=1 from cycle 1.
- WRITE:
  - AWVALID and WVALID deassert independently, the cycle after their own handshake. Per-channel flags aw_done and w_done record completion.
  - BREADY stays high for the whole state. A B handshake captures BRESP into RSP_RESP and sets b_done.
  - B arriving before AW/W complete is tolerated and captured.
  - Exit to RESP when aw_done, w_done and b_done are all set, counting handshakes in the current cycle.
  - Minimum latency against a slave that asserts AWREADY, WREADY and BVALID together: accept at cycle 0, handshake at cycle 2, RSP_VALID at cycle 3.
  - On exit, BREADY drops and RSP_RDATA is set to 0.
- READ:
  - ARVALID holds until ARREADY, then deasserts.
  - RREADY stays high for the whole state. An R handshake captures RDATA and RRESP.
  - Exit to RESP when both ar_done and r_done are set.
- RESP:
  - RSP_VALID=1. RSP_* outputs are stable until RSP_READY.
  - On RSP_VALID&RSP_READY, go to IDLE. CMD_READY rises on the following cycle; there is no same-cycle command accept.
- ERR_CNT increments by 1 on each entry to RESP with RSP_RESP!=2'b00. It saturates at 16'hFFFF.
- Write and read never overlap; only one transaction is outstanding at a time.
- VALID outputs never deassert before their handshake, as required by AXI.
- Address and data outputs are stable while the corresponding VALID is high.

Decomposition:
- Package axi_lite_pkg holds:
  - resp_t codes OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - The state enum {IDLE, WRITE, READ, RESP}.
  - ERR_CNT_W=16.
- No sub-module; the FSM, the done flags and the counter fit in one module.

Test Plan:
- Write to the stencil controller: CMD addr 0x8, data 0x1000_0000, wstrb 0xF -> STENCIL_SRC=0x1000_0000, RSP_VALID with RSP_WRITE=1, RSP_RESP=00, RSP_RDATA=0, ERR_CNT=0.
- Read from the stencil controller: STENCIL_DONE=1, CMD read addr 0x0 -> RSP_RDATA=0x0000_0001, RSP_RESP=00. Same read with addr 0x4 -> RSP_RDATA=0.
- Skewed slave model: AWREADY at cycle 2, WREADY at cycle 5, BVALID at cycle 6 -> AWVALID low from cycle 3, WVALID high until cycle 5, RSP_VALID at cycle 7.
- Error path: slave returns BRESP=10 then RRESP=11 -> RSP_RESP reflects each. ERR_CNT=1 then 2. ERR_CNT preloaded via forced state to 0xFFFF stays 0xFFFF.
- Backpressure: RSP_READY held low 10 cycles -> RSP_* stable, CMD_READY=0, a pending CMD_VALID is not accepted until the cycle after the RSP handshake.
- Reset mid-write: assert AXI_CTRL_ARESET while AWVALID=1 -> AWVALID, WVALID, BREADY and RSP_VALID go 0 immediately with no clock. After release, CMD_READY=1 and a new read completes normally.
